// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings and widths for the pipeline sequencer.
package pipe_ctrl_pkg;

    localparam int INST_ADDR_W = 32;
    localparam int REG_ADDR_W  = 5;

    localparam logic [INST_ADDR_W-1:0] ZERO_WORD     = '0;
    localparam logic [REG_ADDR_W-1:0]  ZERO_REG      = '0;
    localparam logic [INST_ADDR_W-1:0] TRAP_ADDR_DEF = 32'h0000_0100;

    // Encodings are visible on state_o, so they are fixed, not tool-chosen.
    typedef enum logic [1:0] {
        PIPE_RUN      = 2'd0,
        PIPE_MEM_WAIT = 2'd1,
        PIPE_ERR      = 2'd2
    } pipe_state_t;

endpackage

// File: rtl/pipe_ctrl_hazard.sv
// Load-use comparator: flags an ID instruction that reads the register
// a load in EX is about to write. x0 is never a real dependency.
module pipe_ctrl_hazard
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] id_rs1_addr,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic                  ex_is_load,
    input  logic                  ex_reg_we,
    input  logic [REG_ADDR_W-1:0] ex_rd_addr,
    output logic                  lu
);

    logic rs1_hit;
    logic rs2_hit;

    // Per-source match against the EX destination.
    always_comb begin
        rs1_hit = id_rs1_used && (id_rs1_addr == ex_rd_addr);
        rs2_hit = id_rs2_used && (id_rs2_addr == ex_rd_addr);
        lu      = ex_is_load && ex_reg_we && (ex_rd_addr != ZERO_REG)
                  && (rs1_hit || rs2_hit);
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: per-stage hold/flush, PC redirect, data-memory wait
// with timeout, and the bus-error trap state.
//
// state         | meaning
// --------------+---------------------------------------------------------
// PIPE_RUN      | normal flow; memory stall, jump and load-use resolved here
// PIPE_MEM_WAIT | data access outstanding; pipe frozen until ack or timeout
// PIPE_ERR      | bus timed out; pipe frozen until err_clr redirects to trap
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int                     MEM_TIMEOUT = 16,
    parameter logic [INST_ADDR_W-1:0] TRAP_ADDR   = TRAP_ADDR_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [REG_ADDR_W-1:0]  id_rs1_addr,
    input  logic [REG_ADDR_W-1:0]  id_rs2_addr,
    input  logic                   id_rs1_used,
    input  logic                   id_rs2_used,
    input  logic                   ex_is_load,
    input  logic                   ex_reg_we,
    input  logic [REG_ADDR_W-1:0]  ex_rd_addr,
    input  logic                   ex_jump_flag,
    input  logic [INST_ADDR_W-1:0] ex_jump_addr,
    input  logic                   mem_req,
    input  logic                   mem_ack,
    input  logic                   err_clr,
    output logic                   hold_pc,
    output logic                   hold_if_id,
    output logic                   hold_id_ex,
    output logic                   hold_ex_mem,
    output logic                   flush_if_id,
    output logic                   flush_id_ex,
    output logic                   flush_mem_wb,
    output logic                   pc_set,
    output logic [INST_ADDR_W-1:0] pc_set_addr,
    output logic                   bus_err,
    output logic [1:0]             state_o,
    output logic [31:0]            stall_cycles
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

    pipe_state_t state;
    logic [7:0]  wait_cnt;
    logic        lu;
    logic        ms;
    logic        mem_stall;

    pipe_ctrl_hazard u_hazard (
        .id_rs1_addr (id_rs1_addr),
        .id_rs2_addr (id_rs2_addr),
        .id_rs1_used (id_rs1_used),
        .id_rs2_used (id_rs2_used),
        .ex_is_load  (ex_is_load),
        .ex_reg_we   (ex_reg_we),
        .ex_rd_addr  (ex_rd_addr),
        .lu          (lu)
    );

    assign ms      = mem_req && !mem_ack;
    assign state_o = state;

    // Freeze condition: a new un-acked access in RUN, or no ack yet in MEM_WAIT.
    always_comb begin
        mem_stall = 1'b0;
        case (state)
            PIPE_RUN:      mem_stall = ms;
            PIPE_MEM_WAIT: mem_stall = !mem_ack;
            default:       mem_stall = 1'b0;
        endcase
    end

    // Control outputs; everything is forced low while reset is held.
    always_comb begin
        hold_pc      = 1'b0;
        hold_if_id   = 1'b0;
        hold_id_ex   = 1'b0;
        hold_ex_mem  = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        flush_mem_wb = 1'b0;
        pc_set       = 1'b0;
        pc_set_addr  = ZERO_WORD;
        bus_err      = 1'b0;
        if (!rst) begin
            case (state)
                PIPE_RUN, PIPE_MEM_WAIT: begin
                    if (mem_stall) begin
                        // Jump and load-use wait: EX/ID are held and re-evaluated.
                        hold_pc      = 1'b1;
                        hold_if_id   = 1'b1;
                        hold_id_ex   = 1'b1;
                        hold_ex_mem  = 1'b1;
                        flush_mem_wb = 1'b1;
                    end else if (ex_jump_flag) begin
                        // The dependent younger instruction is flushed, so no bubble.
                        flush_if_id = 1'b1;
                        flush_id_ex = 1'b1;
                        pc_set      = 1'b1;
                        pc_set_addr = ex_jump_addr;
                    end else if (lu) begin
                        hold_pc     = 1'b1;
                        hold_if_id  = 1'b1;
                        flush_id_ex = 1'b1;
                    end
                end
                PIPE_ERR: begin
                    bus_err = 1'b1;
                    if (err_clr) begin
                        flush_if_id = 1'b1;
                        flush_id_ex = 1'b1;
                        pc_set      = 1'b1;
                        pc_set_addr = TRAP_ADDR;
                    end else begin
                        hold_pc      = 1'b1;
                        hold_if_id   = 1'b1;
                        hold_id_ex   = 1'b1;
                        hold_ex_mem  = 1'b1;
                        flush_mem_wb = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // FSM and wait counter; the counter holds the number of MEM_WAIT cycles so far.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= PIPE_RUN;
            wait_cnt <= 8'd0;
        end else begin
            case (state)
                PIPE_RUN: begin
                    if (ms) begin
                        state    <= PIPE_MEM_WAIT;
                        wait_cnt <= 8'd1;
                    end
                end
                PIPE_MEM_WAIT: begin
                    if (mem_ack) begin
                        state    <= PIPE_RUN;
                        wait_cnt <= 8'd0;
                    end else if (wait_cnt == TIMEOUT_CNT) begin
                        state    <= PIPE_ERR;
                        wait_cnt <= 8'd0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                PIPE_ERR: begin
                    if (err_clr) begin
                        state <= PIPE_RUN;
                    end
                end
                default: begin
                    state    <= PIPE_RUN;
                    wait_cnt <= 8'd0;
                end
            endcase
        end
    end

    // Stall statistics: one count per cycle the PC is held, wrapping naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= 32'd0;
        end else if (hold_pc) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl. Stimulus pushes the expected outputs of each
// cycle into a queue; a negedge monitor pops and compares.
module tb_pipe_ctrl;

    logic        clk;
    logic        rst;
    logic [4:0]  id_rs1_addr;
    logic [4:0]  id_rs2_addr;
    logic        id_rs1_used;
    logic        id_rs2_used;
    logic        ex_is_load;
    logic        ex_reg_we;
    logic [4:0]  ex_rd_addr;
    logic        ex_jump_flag;
    logic [31:0] ex_jump_addr;
    logic        mem_req;
    logic        mem_ack;
    logic        err_clr;
    logic        hold_pc;
    logic        hold_if_id;
    logic        hold_id_ex;
    logic        hold_ex_mem;
    logic        flush_if_id;
    logic        flush_id_ex;
    logic        flush_mem_wb;
    logic        pc_set;
    logic [31:0] pc_set_addr;
    logic        bus_err;
    logic [1:0]  state_o;
    logic [31:0] stall_cycles;

    pipe_ctrl #(.MEM_TIMEOUT(16), .TRAP_ADDR(32'h0000_0100)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_rs1_addr  (id_rs1_addr),
        .id_rs2_addr  (id_rs2_addr),
        .id_rs1_used  (id_rs1_used),
        .id_rs2_used  (id_rs2_used),
        .ex_is_load   (ex_is_load),
        .ex_reg_we    (ex_reg_we),
        .ex_rd_addr   (ex_rd_addr),
        .ex_jump_flag (ex_jump_flag),
        .ex_jump_addr (ex_jump_addr),
        .mem_req      (mem_req),
        .mem_ack      (mem_ack),
        .err_clr      (err_clr),
        .hold_pc      (hold_pc),
        .hold_if_id   (hold_if_id),
        .hold_id_ex   (hold_id_ex),
        .hold_ex_mem  (hold_ex_mem),
        .flush_if_id  (flush_if_id),
        .flush_id_ex  (flush_id_ex),
        .flush_mem_wb (flush_mem_wb),
        .pc_set       (pc_set),
        .pc_set_addr  (pc_set_addr),
        .bus_err      (bus_err),
        .state_o      (state_o),
        .stall_cycles (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ctl bits: {hold_pc, hold_if_id, hold_id_ex, hold_ex_mem,
    //            flush_if_id, flush_id_ex, flush_mem_wb, pc_set}
    localparam logic [7:0] C_NONE = 8'b0000_0000;
    localparam logic [7:0] C_HOLD = 8'b1111_0010;
    localparam logic [7:0] C_LU   = 8'b1100_0100;
    localparam logic [7:0] C_JUMP = 8'b0000_1101;
    localparam logic [7:0] M_ALL  = 8'hFF;
    localparam logic [7:0] M_NOWB = 8'b1111_1101;

    typedef struct {
        logic [7:0]  ctl;
        logic [7:0]  mask;
        logic [31:0] addr;
        logic        be;
        logic [1:0]  st;
        logic [31:0] stall;
        string       nm;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_stall = 32'd0;

    task automatic idle();
        id_rs1_addr  = 5'd0;
        id_rs2_addr  = 5'd0;
        id_rs1_used  = 1'b0;
        id_rs2_used  = 1'b0;
        ex_is_load   = 1'b0;
        ex_reg_we    = 1'b0;
        ex_rd_addr   = 5'd0;
        ex_jump_flag = 1'b0;
        ex_jump_addr = 32'd0;
        mem_req      = 1'b0;
        mem_ack      = 1'b0;
        err_clr      = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic expect_out(input logic [7:0] ctl, input logic [7:0] mask,
                              input logic [31:0] addr, input logic be,
                              input logic [1:0] st, input string nm);
        exp_t e;
        e.ctl   = ctl;
        e.mask  = mask;
        e.addr  = addr;
        e.be    = be;
        e.st    = st;
        e.stall = exp_stall;
        e.nm    = nm;
        sb.push_back(e);
        if (ctl[7]) exp_stall = exp_stall + 32'd1;
    endtask

    task automatic expect_reset(input string nm);
        exp_stall = 32'd0;
        expect_out(C_NONE, M_ALL, 32'd0, 1'b0, 2'd0, nm);
    endtask

    task automatic set_lu(input logic [4:0] rd);
        ex_is_load  = 1'b1;
        ex_reg_we   = 1'b1;
        ex_rd_addr  = rd;
        id_rs1_addr = 5'd5;
        id_rs1_used = 1'b1;
    endtask

    // Monitor: compares one pushed expectation per cycle at the falling edge.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t        e;
            logic [7:0]  act;
            e   = sb.pop_front();
            act = {hold_pc, hold_if_id, hold_id_ex, hold_ex_mem,
                   flush_if_id, flush_id_ex, flush_mem_wb, pc_set};
            checks++;
            if ((act & e.mask) != (e.ctl & e.mask)) begin
                failures++;
                $display("FAIL %s ctl: got %b want %b (mask %b)", e.nm, act, e.ctl, e.mask);
            end
            if (e.ctl[0]) begin
                checks++;
                if (pc_set_addr != e.addr) begin
                    failures++;
                    $display("FAIL %s pc_set_addr: got %h want %h", e.nm, pc_set_addr, e.addr);
                end
            end
            checks++;
            if (bus_err != e.be) begin
                failures++;
                $display("FAIL %s bus_err: got %b want %b", e.nm, bus_err, e.be);
            end
            checks++;
            if (state_o != e.st) begin
                failures++;
                $display("FAIL %s state_o: got %0d want %0d", e.nm, state_o, e.st);
            end
            checks++;
            if (stall_cycles != e.stall) begin
                failures++;
                $display("FAIL %s stall_cycles: got %0d want %0d", e.nm, stall_cycles, e.stall);
            end
        end
    end

    initial begin
        rst = 1'b1;
        idle();

        // Reset holds every output low even with active inputs.
        tick();
        mem_req = 1'b1; ex_jump_flag = 1'b1; ex_jump_addr = 32'h44; set_lu(5'd5);
        expect_reset("in_reset");

        tick();
        rst = 1'b0;
        expect_out(C_NONE, M_ALL, 32'd0, 1'b0, 2'd0, "post_reset_idle");

        // Load-use on rs1 gives exactly one bubble.
        tick(); set_lu(5'd5);
        expect_out(C_LU, M_ALL, 32'd0, 1'b0, 2'd0, "lu_rs1");
        tick();
        expect_out(C_NONE, M_ALL, 32'd0, 1'b0, 2'd0, "lu_after");

        // Destination x0 never stalls.
        tick(); set_lu(5'd0); id_rs1_addr = 5'd0;
        expect_out(C_NONE, M_ALL, 32'd0, 1'b0, 2'd0, "lu_rd0");

        // rs2 dependency, and an unused rs1 match that must be ignored.
        tick(); ex_is_load = 1'b1; ex_reg_we = 1'b1; ex_rd_addr = 5'd7;
        id_rs2_addr = 5'd7; id_rs2_used = 1'b1;
        expect_out(C_LU, M_ALL, 32'd0, 1'b0, 2'd0, "lu_rs2");
        tick(); ex_is_load = 1'b1; ex_reg_we = 1'b1; ex_rd_addr = 5'd9;
        id_rs1_addr = 5'd9; id_rs1_used = 1'b0;
        expect_out(C_NONE, M_ALL, 32'd0, 1'b0, 2'd0, "lu_rs1_unused");

        // Jump wins over load-use.
        tick(); set_lu(5'd5); ex_jump_flag = 1'b1; ex_jump_addr = 32'h0000_0080;
        expect_out(C_JUMP, M_ALL, 32'h0000_0080, 1'b0, 2'd0, "jump_lu");

        // Zero-wait access with a jump: no stall, jump taken.
        tick(); mem_req = 1'b1; mem_ack = 1'b1; ex_jump_flag = 1'b1; ex_jump_addr = 32'h0000_0044;
        expect_out(C_JUMP, M_ALL, 32'h0000_0044, 1'b0, 2'd0, "zero_wait_jump");

        // Memory wait with ack on the third MEM_WAIT cycle; jump is deferred at entry.
        tick(); mem_req = 1'b1; ex_jump_flag = 1'b1; ex_jump_addr = 32'h0000_0080;
        expect_out(C_HOLD, M_ALL, 32'd0, 1'b0, 2'd0, "mw_enter");
        tick(); mem_req = 1'b1;
        expect_out(C_HOLD, M_ALL, 32'd0, 1'b0, 2'd1, "mw_wait1");
        tick(); mem_req = 1'b1;
        expect_out(C_HOLD, M_ALL, 32'd0, 1'b0, 2'd1, "mw_wait2");
        tick(); mem_req = 1'b1; mem_ack = 1'b1; ex_jump_flag = 1'b1; ex_jump_addr = 32'h0000_0080;
        expect_out(C_JUMP, M_ALL, 32'h0000_0080, 1'b0, 2'd1, "mw_ack_jump");
        tick();
        expect_out(C_NONE, M_ALL, 32'd0, 1'b0, 2'd0, "mw_back_run");

        // Timeout: 16 MEM_WAIT cycles without ack, then ERR.
        tick(); mem_req = 1'b1;
        expect_out(C_HOLD, M_ALL, 32'd0, 1'b0, 2'd0, "to_enter");
        for (int i = 0; i < 16; i++) begin
            tick(); mem_req = 1'b1;
            expect_out(C_HOLD, M_ALL, 32'd0, 1'b0, 2'd1, "to_wait");
        end
        tick(); mem_req = 1'b1; mem_ack = 1'b1;
        expect_out(C_HOLD, M_ALL, 32'd0, 1'b1, 2'd2, "err_ack_ignored");
        tick();
        expect_out(C_HOLD, M_ALL, 32'd0, 1'b1, 2'd2, "err_hold");
        tick(); err_clr = 1'b1;
        expect_out(C_JUMP, M_NOWB, 32'h0000_0100, 1'b1, 2'd2, "err_clr_trap");
        tick();
        expect_out(C_NONE, M_ALL, 32'd0, 1'b0, 2'd0, "err_cleared");

        // Ack on the timeout cycle returns to RUN without error.
        tick(); mem_req = 1'b1;
        expect_out(C_HOLD, M_ALL, 32'd0, 1'b0, 2'd0, "tack_enter");
        for (int i = 0; i < 15; i++) begin
            tick(); mem_req = 1'b1;
            expect_out(C_HOLD, M_ALL, 32'd0, 1'b0, 2'd1, "tack_wait");
        end
        tick(); mem_req = 1'b1; mem_ack = 1'b1;
        expect_out(C_NONE, M_ALL, 32'd0, 1'b0, 2'd1, "tack_ack");
        tick();
        expect_out(C_NONE, M_ALL, 32'd0, 1'b0, 2'd0, "tack_run");

        // Asynchronous reset between edges while in MEM_WAIT.
        tick(); mem_req = 1'b1;
        expect_out(C_HOLD, M_ALL, 32'd0, 1'b0, 2'd0, "ar_enter");
        tick(); mem_req = 1'b1;
        expect_out(C_HOLD, M_ALL, 32'd0, 1'b0, 2'd1, "ar_wait");
        tick(); mem_req = 1'b1;
        #2 rst = 1'b1;
        expect_reset("ar_mid_wait");
        tick(); rst = 1'b0;
        expect_out(C_NONE, M_ALL, 32'd0, 1'b0, 2'd0, "ar_released");

        // Counter restarts from zero after the abort: a fresh 16-cycle wait reaches ERR.
        tick(); mem_req = 1'b1;
        expect_out(C_HOLD, M_ALL, 32'd0, 1'b0, 2'd0, "ar2_enter");
        for (int i = 0; i < 16; i++) begin
            tick(); mem_req = 1'b1;
            expect_out(C_HOLD, M_ALL, 32'd0, 1'b0, 2'd1, "ar2_wait");
        end
        tick();
        expect_out(C_HOLD, M_ALL, 32'd0, 1'b1, 2'd2, "ar2_err");

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d entries left, want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central pipeline sequencer for the 5-stage RISC-V core.
- Generates per-stage hold and flush controls for the PC, IF-ID, ID-EX, EX-MEM and MEM-WB pipeline registers, and drives PC redirects.
- Resolves three hazard classes: load-use data hazards, EX-stage jumps/branches, and multi-cycle data-memory accesses (req/ack with timeout).
- A small FSM handles the memory wait and the bus-error trap.

Parameters:
- MEM_TIMEOUT, 16, cycles in MEM_WAIT without ack before bus error (2..255).
- TRAP_ADDR, 32'h0000_0100, PC loaded when leaving the ERR state.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- id_rs1_addr  in  5  ID-stage rs1 index
- id_rs2_addr  in  5  ID-stage rs2 index
- id_rs1_used  in  1  ID instruction reads rs1
- id_rs2_used  in  1  ID instruction reads rs2
- ex_is_load  in  1  EX instruction is a load
- ex_reg_we  in  1  EX instruction writes rd
- ex_rd_addr  in  5  EX destination index
- ex_jump_flag  in  1  EX resolved taken jump/branch
- ex_jump_addr  in  32  jump target
- mem_req  in  1  MEM-stage load/store active
- mem_ack  in  1  data bus completes access this cycle
- err_clr  in  1  software/debug acknowledge of bus error
- hold_pc  out  1  PC holds value
- hold_if_id  out  1  IF-ID register holds
- hold_id_ex  out  1  ID-EX register holds
- hold_ex_mem  out  1  EX-MEM register holds
- flush_if_id  out  1  IF-ID loads NOP
- flush_id_ex  out  1  ID-EX loads NOP
- flush_mem_wb  out  1  MEM-WB loads NOP (bubble)
- pc_set  out  1  PC loads pc_set_addr next edge
- pc_set_addr  out  32  redirect target
- bus_err  out  1  sticky bus-error indicator
- state_o  out  2  FSM state (debug)
- stall_cycles  out  32  count of cycles with hold_pc=1

Behaviour:
- Reset is asynchronous and active-high on rst; clock is clk. Reset forces state=RUN, timeout counter=0, stall_cycles=0. While rst is high, every output is 0 and pc_set_addr=0.
- Control outputs are combinational from the registered state and current inputs. Only state, counter and stall_cycles are flops.
- The load-use condition `lu` = ex_is_load & ex_reg_we & (ex_rd_addr != 0) & ((id_rs1_used & rs1 == rd) | (id_rs2_used & rs2 == rd)).
- The memory-stall condition `ms` = mem_req & ~mem_ack.
- FSM states: RUN=2'd0, MEM_WAIT=2'd1, ERR=2'd2. Code 2'd3 is illegal and returns to RUN.
- RUN, priority ms > jump > lu:
  - ms: assert hold_pc/if_id/id_ex/ex_mem and flush_mem_wb; next state MEM_WAIT, counter=1. Any jump or lu is deferred, because the EX/ID contents are held and re-evaluated later.
  - ex_jump_flag: assert flush_if_id, flush_id_ex, pc_set, pc_set_addr=ex_jump_addr. The lu stall is suppressed, since the younger instruction is flushed.
  - lu: assert hold_pc, hold_if_id, flush_id_ex. This gives exactly a one-cycle bubble; next cycle the load is in MEM and lu is clear.
  - mem_req & mem_ack in the same cycle: zero-wait access, no stall.
- MEM_WAIT:
  - Holds and flush_mem_wb stay asserted while mem_ack=0, and the counter increments.
  - mem_ack=1: no holds that cycle; next state RUN, counter=0. Jump/lu logic as in RUN applies in that same cycle.
  - Counter reaches MEM_TIMEOUT with no ack: next state ERR.
  - An ack arriving in the same cycle as the timeout wins; the next state is RUN.
- ERR:
  - bus_err=1; all holds and flush_mem_wb asserted; mem_ack ignored.
  - err_clr=1: pc_set=1, pc_set_addr=TRAP_ADDR, flush_if_id, flush_id_ex, holds released; next state RUN, bus_err clears the next cycle.
- stall_cycles increments every cycle hold_pc=1 and wraps at 2^32.
- Reset asserted mid-MEM_WAIT aborts immediately: state=RUN, counter=0.

Decomposition:
- Shared defines.v additions:
  - `PIPE_RUN`, `PIPE_MEM_WAIT`, `PIPE_ERR` state encodings.
  - `TRAP_ADDR` default.
  - Reuse of `ZeroWord`, `ZeroReg`, `InstAddrBus`, `RegAddrBus`.
- One sub-module: pipe_ctrl_hazard, the combinational load-use comparator producing lu. The FSM, counter and output muxing stay in pipe_ctrl.

Test Plan:
- Load-use: ex_is_load=1, ex_reg_we=1, ex_rd_addr=5, id_rs1_addr=5, id_rs1_used=1 → one cycle of hold_pc=hold_if_id=flush_id_ex=1; stall_cycles 0→1. Repeat with ex_rd_addr=0 → no stall.
- Jump + load-use together: ex_jump_flag=1, ex_jump_addr=32'h0000_0080, lu true → pc_set=1, addr 0x80, flush_if_id=flush_id_ex=1, hold_pc=0.
- Memory wait: mem_req=1, ack after 3 cycles → state_o=1 for 3 cycles, holds+flush_mem_wb high 3 cycles; ack cycle holds low; stall_cycles=3.
- Timeout: mem_req=1, no ack, MEM_TIMEOUT=16 → ERR after 16 MEM_WAIT cycles, bus_err=1. Then err_clr=1 → pc_set_addr=0x100, state_o=0.
- Ack on the timeout cycle → returns to RUN, bus_err stays 0.
- Async reset mid-wait: rst pulse between edges in MEM_WAIT → outputs 0 immediately, state_o=0, stall_cycles=0.
